// File: rtl/rf_pkg.sv
// ============================================================================
// Module      : rf_pkg
// Description : Shared types and default sizes for the parametrised register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;

    localparam int RF_DATA_W_DEF = 8;
    localparam int RF_ADDR_W_DEF = 4;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

endpackage : rf_pkg

`default_nettype wire

// File: rtl/register_file_param_if.sv
// ============================================================================
// Module      : register_file_param_if
// Description : Write/read/clear bus between the ALU side and the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface register_file_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              writeEnable;
    logic [ADDR_W-1:0] replaceSel;
    logic [DATA_W-1:0] replaceData;
    logic [ADDR_W-1:0] A_sel;
    logic [ADDR_W-1:0] B_sel;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [DATA_W-1:0] RLast_out;
    logic              clearReq;
    logic              busy;
    logic              clearDone;
    logic              writeDropped;

    modport master (
        output writeEnable, replaceSel, replaceData, A_sel, B_sel, clearReq,
        input  A, B, RLast_out, busy, clearDone, writeDropped
    );

    modport slave (
        input  writeEnable, replaceSel, replaceData, A_sel, B_sel, clearReq,
        output A, B, RLast_out, busy, clearDone, writeDropped
    );
endinterface : register_file_param_if

`default_nettype wire

// File: rtl/rf_clear_seq.sv
// ============================================================================
// Module      : rf_clear_seq
// Description : Clear sweep sequencer: walks ptr over every entry, one per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W_DEF
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              clear_req,
    output logic                   busy,
    output logic                   clear_we,
    output logic [ADDR_W-1:0]      clear_ptr,
    output logic                   clear_done
);

    localparam logic [ADDR_W-1:0] c_PTR_LAST = '1;

    rf_state_t         r_state;
    rf_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              r_done;
    logic              w_done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RF_IDLE;
            r_ptr   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_done_nxt  = 1'b0;
        case (r_state)
            RF_IDLE: begin
                if (clear_req) begin
                    w_state_nxt = RF_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            RF_CLEAR: begin
                // Increment wraps the pointer back to 0 on the final entry.
                w_ptr_nxt = r_ptr + ADDR_W'(1);
                if (r_ptr == c_PTR_LAST) begin
                    w_state_nxt = RF_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = RF_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign busy       = (r_state == RF_CLEAR);
    assign clear_we   = busy;
    assign clear_ptr  = r_ptr;
    assign clear_done = r_done;

endmodule : rf_clear_seq

`default_nettype wire

// File: rtl/register_file_param.sv
// ============================================================================
// Module      : register_file_param
// Description : 2**ADDR_W x DATA_W register file, two async read ports, optional
//               write bypass, hardware clear sweep. Macro RF_ZERO_REG_EN makes
//               entry 0 a hardwired zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_param
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W_DEF,
    parameter int ADDR_W = RF_ADDR_W_DEF,
    parameter int BYPASS = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    register_file_param_if.slave  bus
);

    localparam int                c_DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST  = '1;
`ifdef RF_ZERO_REG_EN
    localparam bit                c_ZERO_REG = 1'b1;
`else
    localparam bit                c_ZERO_REG = 1'b0;
`endif

    logic [DATA_W-1:0] r_regs [c_DEPTH];
    logic              r_drop;

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_ptr;
    logic              w_clr_done;
    logic              w_wr_zero;
    logic              w_wr_acc;
    logic              w_byp_a;
    logic              w_byp_b;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;

    rf_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .clear_req  (bus.clearReq),
        .busy       (w_busy),
        .clear_we   (w_clr_we),
        .clear_ptr  (w_clr_ptr),
        .clear_done (w_clr_done)
    );

    // Writes to a hardwired-zero entry vanish without being reported as dropped.
    assign w_wr_zero = c_ZERO_REG && (bus.replaceSel == '0);
    assign w_wr_acc  = bus.writeEnable && !w_busy && !w_wr_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_clr_we) begin
            r_regs[w_clr_ptr] <= '0;
        end else if (w_wr_acc) begin
            r_regs[bus.replaceSel] <= bus.replaceData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= bus.writeEnable && w_busy;
        end
    end

    generate
        if (BYPASS != 0) begin : g_bypass
            assign w_byp_a = w_wr_acc && (bus.replaceSel == bus.A_sel);
            assign w_byp_b = w_wr_acc && (bus.replaceSel == bus.B_sel);
        end else begin : g_no_bypass
            assign w_byp_a = 1'b0;
            assign w_byp_b = 1'b0;
        end
    endgenerate

    always_comb begin
        w_a = r_regs[bus.A_sel];
        if (c_ZERO_REG && (bus.A_sel == '0)) begin
            w_a = '0;
        end
        if (w_byp_a) begin
            w_a = bus.replaceData;
        end
    end

    always_comb begin
        w_b = r_regs[bus.B_sel];
        if (c_ZERO_REG && (bus.B_sel == '0)) begin
            w_b = '0;
        end
        if (w_byp_b) begin
            w_b = bus.replaceData;
        end
    end

    assign bus.A            = w_a;
    assign bus.B            = w_b;
    assign bus.RLast_out    = r_regs[c_LAST];
    assign bus.busy         = w_busy;
    assign bus.clearDone    = w_clr_done;
    assign bus.writeDropped = r_drop;

endmodule : register_file_param

`default_nettype wire

// File: tb/tb_register_file_param.sv
// ============================================================================
// Module      : tb_register_file_param
// Description : Directed bench for register_file_param; a BYPASS=1 and a BYPASS=0
//               instance share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we  = 1'b0;
    logic [3:0] wsel  = '0;
    logic [7:0] wdata = '0;
    logic [3:0] asel  = '0;
    logic [3:0] bsel  = '0;
    logic       clr_req = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    register_file_param_if #(.DATA_W(8), .ADDR_W(4)) bus_b ();
    register_file_param_if #(.DATA_W(8), .ADDR_W(4)) bus_n ();

    assign bus_b.writeEnable = we;
    assign bus_b.replaceSel  = wsel;
    assign bus_b.replaceData = wdata;
    assign bus_b.A_sel       = asel;
    assign bus_b.B_sel       = bsel;
    assign bus_b.clearReq    = clr_req;
    assign bus_n.writeEnable = we;
    assign bus_n.replaceSel  = wsel;
    assign bus_n.replaceData = wdata;
    assign bus_n.A_sel       = asel;
    assign bus_n.B_sel       = bsel;
    assign bus_n.clearReq    = clr_req;

    register_file_param #(.DATA_W(8), .ADDR_W(4), .BYPASS(1)) u_dut_byp (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    register_file_param #(.DATA_W(8), .ADDR_W(4), .BYPASS(0)) u_dut_nobyp (
        .clk (clk),
        .rst (rst),
        .bus (bus_n.slave)
    );

    typedef struct {
        logic       we;
        logic [3:0] wsel;
        logic [7:0] wdata;
        logic [3:0] asel;
        logic [3:0] bsel;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] ea_nb;
        logic [7:0] elast;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            we    = 1'b1;
            wsel  = 4'(i);
            wdata = base + 8'(i);
            step();
        end
        we = 1'b0;
    endtask

    int         busy_cnt;
    int         done_cnt;
    int         done_cyc;
    logic [7:0] r0v;
    logic [7:0] r0_byp;

    initial begin
`ifdef RF_ZERO_REG_EN
        r0v    = 8'h00;
        r0_byp = 8'h00;
`else
        r0v    = 8'hAA;
        r0_byp = 8'hAA;
`endif
        //          we    wsel   wdata  asel   bsel   A      B      A(nobyp) RLast
        vecs[0] = '{1'b0, 4'd0,  8'h00, 4'd0,  4'd15, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 4'd3,  8'h5A, 4'd3,  4'd0,  8'h5A, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{1'b1, 4'd15, 8'hFF, 4'd3,  4'd15, 8'h5A, 8'hFF, 8'h5A, 8'h00};
        vecs[3] = '{1'b0, 4'd0,  8'h00, 4'd15, 4'd3,  8'hFF, 8'h5A, 8'hFF, 8'hFF};
        vecs[4] = '{1'b1, 4'd7,  8'h33, 4'd7,  4'd7,  8'h33, 8'h33, 8'h00, 8'hFF};
        vecs[5] = '{1'b1, 4'd7,  8'h44, 4'd7,  4'd3,  8'h44, 8'h5A, 8'h33, 8'hFF};
        vecs[6] = '{1'b0, 4'd0,  8'h00, 4'd7,  4'd7,  8'h44, 8'h44, 8'h44, 8'hFF};
        vecs[7] = '{1'b1, 4'd0,  8'hAA, 4'd0,  4'd1,  r0_byp, 8'h00, 8'h00, 8'hFF};
        vecs[8] = '{1'b0, 4'd0,  8'h00, 4'd0,  4'd0,  r0v,   r0v,   r0v,   8'hFF};

        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset_busy", 32'(bus_b.busy), 32'd0);
        chk("reset_clear_done", 32'(bus_b.clearDone), 32'd0);

        for (int v = 0; v < 9; v++) begin
            we    = vecs[v].we;
            wsel  = vecs[v].wsel;
            wdata = vecs[v].wdata;
            asel  = vecs[v].asel;
            bsel  = vecs[v].bsel;
            #2;
            chk($sformatf("vec%0d_A", v), 32'(bus_b.A), 32'(vecs[v].ea));
            chk($sformatf("vec%0d_B", v), 32'(bus_b.B), 32'(vecs[v].eb));
            chk($sformatf("vec%0d_A_nobyp", v), 32'(bus_n.A), 32'(vecs[v].ea_nb));
            chk($sformatf("vec%0d_RLast", v), 32'(bus_b.RLast_out), 32'(vecs[v].elast));
            chk($sformatf("vec%0d_dropped", v), 32'(bus_b.writeDropped), 32'd0);
            step();
        end
        we = 1'b0;

        // Full sweep with a dropped write and an ignored clearReq inside it.
        fill(8'h10);
        asel = 4'd5;
        #1;
        chk("fill_r5", 32'(bus_b.A), 32'h15);
        chk("fill_rlast", 32'(bus_b.RLast_out), 32'h1F);
        clr_req = 1'b1;
        step();
        clr_req  = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (bus_b.busy) busy_cnt++;
            if (bus_b.clearDone) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cyc == 3) begin
                we = 1'b1; wsel = 4'd5; wdata = 8'h11; asel = 4'd5; bsel = 4'd1;
                #1;
                chk("sweep_no_bypass_A", 32'(bus_b.A), 32'h15);
                chk("sweep_swept_B", 32'(bus_b.B), 32'h00);
            end
            if (cyc == 4) begin
                chk("sweep_dropped_pulse", 32'(bus_b.writeDropped), 32'd1);
                we = 1'b0;
            end
            if (cyc == 5) begin
                chk("sweep_dropped_clear", 32'(bus_b.writeDropped), 32'd0);
                clr_req = 1'b1;
            end
            if (cyc == 6) clr_req = 1'b0;
            step();
        end
        chk("sweep_busy_cycles", 32'(busy_cnt), 32'd16);
        chk("sweep_done_count", 32'(done_cnt), 32'd1);
        chk("sweep_done_cycle", 32'(done_cyc), 32'd17);
        for (int i = 0; i < 16; i++) begin
            asel = 4'(i);
            bsel = 4'(15 - i);
            #1;
            chk($sformatf("swept_A_r%0d", i), 32'(bus_b.A), 32'd0);
            chk($sformatf("swept_nb_B_r%0d", 15 - i), 32'(bus_n.B), 32'd0);
        end

        // Reset during the sweep aborts it without a completion pulse.
        fill(8'h80);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 1; k < 8; k++) step();
        chk("abort_busy_before", 32'(bus_b.busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy_after", 32'(bus_b.busy), 32'd0);
        done_cnt = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (bus_b.clearDone) done_cnt++;
            step();
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        for (int i = 0; i < 16; i++) begin
            asel = 4'(i);
            #1;
            chk($sformatf("abort_r%0d", i), 32'(bus_b.A), 32'd0);
        end
        chk("abort_rlast", 32'(bus_b.RLast_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_register_file_param

`default_nettype wire
